// File: rtl/alu_divider_if.sv
// Request/response bundle for the 32-bit divider: operands and opcode in, result and status out.
// Latency: none (wires only).
// Backpressure: the requester must watch busy; start is ignored while busy is high.
interface alu_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, a, b, opcode,
        input  y, busy, done, div_by_zero
    );

    modport slave (
        input  start, a, b, opcode,
        output y, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Sequential restoring radix-2 divider: DIVS/DIVU/MODS/MODU and signed 16.16 fixed-point divide.
// Latency: done 34 cycles after start (50 for FPDIVS, 2 for a zero divisor), no bubble between ops.
// Backpressure: start is sampled only while idle; requests arriving while busy are dropped.
module alu_divider (
    input  logic         clk,
    input  logic         reset,
    alu_divider_if.slave dif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_DIVS   = 3'b000;
    localparam logic [2:0] OP_MODS   = 3'b010;
    localparam logic [2:0] OP_MODU   = 3'b011;
    localparam logic [2:0] OP_FPDIVS = 3'b100;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [47:0] quo_q, quo_d;       // dividend bits shift out of the top, quotient bits shift in below
    logic [31:0] div_q, div_d;       // divisor magnitude
    logic [2:0]  op_q, op_d;
    logic        sa_q, sa_d;         // dividend was negative (signed ops only)
    logic        sb_q, sb_d;         // divisor was negative (signed ops only)
    logic        dz_q, dz_d;         // current operation has a zero divisor
    logic [31:0] y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        in_signed;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] q_res;
    logic [31:0] r_res;
    logic        is_mod;
    logic [31:0] fix_res;

    // Operand conditioning at the request port: signed ops divide magnitudes.
    always_comb begin
        in_signed = (dif.opcode == OP_DIVS) || (dif.opcode == OP_MODS) || (dif.opcode == OP_FPDIVS);
        in_mag_a  = (in_signed && dif.a[31]) ? (~dif.a + 32'd1) : dif.a;
        in_mag_b  = (in_signed && dif.b[31]) ? (~dif.b + 32'd1) : dif.b;
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial = {rem_q, quo_q[47]};
        ge    = (trial >= {1'b0, div_q});
    end

    // Sign fix-up and zero-divisor substitution applied in FIX.
    always_comb begin
        q_res  = (sa_q ^ sb_q) ? (~quo_q[31:0] + 32'd1) : quo_q[31:0];
        r_res  = sa_q ? (~rem_q + 32'd1) : rem_q;
        is_mod = (op_q == OP_MODS) || (op_q == OP_MODU);
        if (is_mod) begin
            // A zero divisor leaves |a| in the remainder, so this also returns a unchanged.
            fix_res = r_res;
        end else if (dz_q) begin
            fix_res = 32'hFFFF_FFFF;
        end else begin
            // Both 32-step and 48-step runs leave the quotient's low 32 bits in quo_q[31:0].
            fix_res = q_res;
        end
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        y_d     = y_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (dif.start) begin
                    op_d  = dif.opcode;
                    div_d = in_mag_b;
                    sa_d  = in_signed & dif.a[31];
                    sb_d  = in_signed & dif.b[31];
                    // Loading |a| above 16 zero bits serves both widths: 32 steps consume |a|,
                    // 48 steps consume the full 16.16-scaled dividend.
                    quo_d = {in_mag_a, 16'h0000};
                    cnt_d = (dif.opcode == OP_FPDIVS) ? 6'd48 : 6'd32;
                    if (dif.b == 32'd0) begin
                        dz_d    = 1'b1;
                        rem_d   = in_mag_a;
                        state_d = ST_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = 32'd0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                quo_d = {quo_q[46:0], ge};
                rem_d = ge ? (trial[31:0] - div_q) : trial[31:0];
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                y_d     = fix_res;
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous active-low reset; an abort never produces done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 48'd0;
            div_q   <= 32'd0;
            op_q    <= 3'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            y_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign dif.y           = y_q;
    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed vector table, reset/back-to-back sequences, random ops.
// Latency: measures done cycle relative to the start-sampling edge.
// Backpressure: injects spurious start pulses while busy to confirm they are dropped.
module tb_alu_divider;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    alu_divider_if dif ();

    alu_divider u_dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, truncating division.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        logic [31:0] y;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y  = 32'd0;
        if (b == 32'd0) begin
            y = (op == 3'd2 || op == 3'd3) ? a : 32'hFFFF_FFFF;
        end else begin
            case (op)
                3'd0: begin q = sa / sb; y = q[31:0]; end
                3'd2: begin q = sa % sb; y = q[31:0]; end
                3'd3: y = a % b;
                3'd4: begin q = (sa * 64'sd65536) / sb; y = q[31:0]; end
                default: y = a / b;
            endcase
        end
        return {(b == 32'd0), y};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (op == 3'd4) return 50;
        return 34;
    endfunction

    // Caller is positioned 1 time unit after a rising edge; the next edge samples start.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject,
                          output logic [31:0] y, output logic dz, output int lat, output logic busy_ok);
        int cyc;
        dif.start  = 1'b1;
        dif.opcode = op;
        dif.a      = a;
        dif.b      = b;
        @(posedge clk); #1;
        cyc        = 1;
        dif.start  = 1'b0;
        busy_ok    = 1'b1;
        lat        = -1;
        y          = 32'd0;
        dz         = 1'b0;
        while (cyc <= 60) begin
            if (dif.done) begin
                lat = cyc;
                y   = dif.y;
                dz  = dif.div_by_zero;
                if (dif.busy) busy_ok = 1'b0;
                break;
            end
            if (!dif.busy) busy_ok = 1'b0;
            if (inject && cyc == 3) begin
                dif.start  = 1'b1;
                dif.opcode = 3'($urandom_range(0, 7));
                dif.a      = $urandom;
                dif.b      = $urandom;
            end
            if (cyc == 4) dif.start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        logic [31:0] ry;
        logic        rdz;
        int          rlat;
        logic        rbusy;
        logic [32:0] m;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n_done;
        int          dcyc [2];
        logic [31:0] dy [2];
        logic        saw_done;
        int          cyc;

        n_checks = 0;
        n_errors = 0;

        vec[0]  = '{3'd1, 32'd100,        32'd7,          32'd14,         1'b0, 34};
        vec[1]  = '{3'd3, 32'd100,        32'd7,          32'd2,          1'b0, 34};
        vec[2]  = '{3'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
        vec[3]  = '{3'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
        vec[4]  = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 34};
        vec[5]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 34};
        vec[6]  = '{3'd4, 32'h0001_0000,  32'h0002_0000,  32'h0000_8000,  1'b0, 50};
        vec[7]  = '{3'd4, 32'hFFFF_0000,  32'h0004_0000,  32'hFFFF_C000,  1'b0, 50};
        vec[8]  = '{3'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 2};
        vec[9]  = '{3'd2, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1, 2};
        vec[10] = '{3'd7, 32'd100,        32'd7,          32'd14,         1'b0, 34};
        vec[11] = '{3'd3, 32'd7,          32'd0,          32'd7,          1'b1, 2};
        vec[12] = '{3'd4, 32'h0001_0000,  32'd0,          32'hFFFF_FFFF,  1'b1, 2};

        dif.start  = 1'b0;
        dif.opcode = 3'd0;
        dif.a      = 32'd0;
        dif.b      = 32'd0;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", dif.y, 32'd0);
        chk("reset_busy", {31'd0, dif.busy}, 32'd0);
        chk("reset_done", {31'd0, dif.done}, 32'd0);
        chk("reset_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, (vec[i].lat > 4), ry, rdz, rlat, rbusy);
            chk($sformatf("vec%0d_y", i), ry, vec[i].y);
            chk($sformatf("vec%0d_dbz", i), {31'd0, rdz}, {31'd0, vec[i].dz});
            chk($sformatf("vec%0d_lat", i), 32'(rlat), 32'(vec[i].lat));
            chk($sformatf("vec%0d_busy", i), {31'd0, rbusy}, 32'd1);
        end

        // Reset in cycle 10 of DIVU 100/7, with start also raised during reset
        dif.start = 1'b1; dif.opcode = 3'd1; dif.a = 32'd100; dif.b = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset     = 1'b0;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("abort_y", dif.y, 32'd0);
        chk("abort_busy", {31'd0, dif.busy}, 32'd0);
        chk("abort_done", {31'd0, dif.done}, 32'd0);
        chk("abort_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        reset    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_op(3'd1, 32'd9, 32'd3, 1'b1, ry, rdz, rlat, rbusy);
        chk("after_abort_y", ry, 32'd3);
        chk("after_abort_lat", 32'(rlat), 32'd34);

        // Back-to-back with start held high; operands changed while busy must be ignored
        dif.start = 1'b1; dif.opcode = 3'd1; dif.a = 32'd100; dif.b = 32'd7;
        @(posedge clk); #1;
        cyc    = 1;
        dif.a  = 32'd50;
        dif.b  = 32'd5;
        n_done = 0;
        dcyc[0] = -1; dcyc[1] = -1; dy[0] = 32'd0; dy[1] = 32'd0;
        while (cyc <= 80) begin
            if (dif.done) begin
                if (n_done < 2) begin
                    dcyc[n_done] = cyc;
                    dy[n_done]   = dif.y;
                end
                n_done++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 35) dif.start = 1'b0;
        end
        chk("b2b_count", 32'(n_done), 32'd2);
        chk("b2b_cyc0", 32'(dcyc[0]), 32'd34);
        chk("b2b_cyc1", 32'(dcyc[1]), 32'd68);
        chk("b2b_y0", dy[0], 32'd14);
        chk("b2b_y1", dy[1], 32'd10);

        // Random operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            m = model(op, ra, rb);
            run_op(op, ra, rb, (exp_lat(op, rb) > 4), ry, rdz, rlat, rbusy);
            chk($sformatf("rnd%0d_op%0d_y", i, op), ry, m[31:0]);
            chk($sformatf("rnd%0d_dbz", i), {31'd0, rdz}, {31'd0, m[32]});
            chk($sformatf("rnd%0d_lat", i), 32'(rlat), 32'(exp_lat(op, rb)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state updates SHALL occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request; SHALL be sampled only while busy=0.
REQ-005 a  input  32  dividend.
REQ-006 b  input  32  divisor.
REQ-007 opcode  input  3  operation: 000 DIVS, 001 DIVU, 010 MODS, 011 MODU, 100 FPDIVS (16.16 signed); 101-111 SHALL execute as DIVU.
REQ-008 y  output  32  registered result; holds its value between operations.
REQ-009 busy  output  1  registered; high whenever state is not IDLE.
REQ-010 done  output  1  registered single-cycle completion pulse.
REQ-011 div_by_zero  output  1  registered; set with done when b=0, otherwise cleared with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and opcode.
  - Signed ops: SHALL latch magnitudes plus the sign of a and the sign of b.
  - b=0: SHALL go to FIX.
  - Otherwise: SHALL go to CALC.
REQ-014 Inputs a, b, opcode and start SHALL be ignored while busy=1.
REQ-015 CALC SHALL be a restoring radix-2 divide producing one quotient bit per cycle.
  - Iteration count N: 32 for all ops except FPDIVS; 48 for FPDIVS.
  - FPDIVS dividend: the magnitude of a, concatenated with 16 zero bits (48 bits).
REQ-016 After N CALC cycles the FSM SHALL enter FIX for exactly one cycle, then return to IDLE.
REQ-017 FIX SHALL write y and pulse done, so that done is high in cycle N+2 after the start-sampling cycle.
  - DIVU/DIVS/MODS/MODU: cycle 34.
  - FPDIVS: cycle 50.
  - b=0: cycle 2.
REQ-018 Quotient sign (DIVS, FPDIVS): negative iff the sign of a differs from the sign of b; two's-complement negate applied after CALC.
REQ-019 Remainder sign (MODS): SHALL follow the dividend (truncating division).
REQ-020 FPDIVS result SHALL be the low 32 bits of the 48-bit quotient after sign fix; upper bits are discarded without saturation.
REQ-021 Division by zero SHALL give div_by_zero=1 and the following y:
  - DIV*/FPDIVS: 0xFFFFFFFF.
  - MOD*: a unmodified.
REQ-022 DIVS 0x80000000 / 0xFFFFFFFF SHALL give y=0x80000000; MODS of the same operands SHALL give y=0.
REQ-023 The start-sampling window and completion SHALL overlap so back-to-back operations incur no bubble:
  - done is high during the first IDLE cycle.
  - start=1 in that same cycle SHALL begin a new operation.
  - done SHALL then deassert on the next edge.
REQ-024 y and div_by_zero SHALL change only in FIX or on reset.

Reset
REQ-025 On reset=0 at a clock edge, including mid-CALC or mid-FIX, the block SHALL apply all of the following on that edge:
  - state -> IDLE.
  - y=0, busy=0, done=0, div_by_zero=0.
  - Internal counter, remainder and quotient registers cleared.
  - No done pulse issued for the aborted operation.
REQ-026 While reset=0, start SHALL be ignored.

Verification
REQ-027 DIVU a=100, b=7 -> y=14, done in cycle 34, busy high in cycles 1-33; MODU with the same operands -> y=2.
REQ-028 Signed results:
  - DIVS a=0xFFFFFFF9 (-7), b=2 -> y=0xFFFFFFFD (-3).
  - MODS with the same operands -> y=0xFFFFFFFF (-1).
  - DIVS 0x80000000 / 0xFFFFFFFF -> y=0x80000000.
REQ-029 Fixed point: FPDIVS a=0x00010000 (1.0), b=0x00020000 (2.0) -> y=0x00008000, done in cycle 50.
  - FPDIVS a=0xFFFF0000 (-1.0), b=0x00040000 -> y=0xFFFFC000.
REQ-030 Divide by zero: DIVU a=5, b=0 -> y=0xFFFFFFFF, div_by_zero=1, done in cycle 2; MODS a=0xFFFFFFF9, b=0 -> y=0xFFFFFFF9.
REQ-031 Reset mid-CALC: assert reset in cycle 10 of DIVU 100/7 -> y=0 and busy=0 next cycle, no done; a new DIVU 9/3 started after release -> y=3.
REQ-032 Back-to-back: start held high continuously for DIVU 100/7 then DIVU 50/5 -> done pulses in cycles 34 and 68, y=14 then y=10.
  - start pulses issued while busy=1 SHALL have no effect.
